// File: rtl/axil_mitm_wr.sv
// AXI4-lite write-path man-in-the-middle: captures AW and W independently, reissues
// them downstream as a single outstanding write, and returns the B response, all registered.
module axil_mitm_wr #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // once valid is raised it holds, with its payload stable, until that edge.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    RESP  = 3'b100
  } state_t;

  state_t                state_q, state_d;
  logic                  s_awready_q, s_awready_d;
  logic                  s_wready_q, s_wready_d;
  logic                  s_bvalid_q, s_bvalid_d;
  logic [1:0]            s_bresp_q, s_bresp_d;
  logic                  m_awvalid_q, m_awvalid_d;
  logic                  m_wvalid_q, m_wvalid_d;
  logic                  m_bready_q, m_bready_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic [ADDR_WIDTH-1:0] m_awaddr_q;
  logic [2:0]            m_awprot_q;
  logic [DATA_WIDTH-1:0] m_wdata_q;
  logic [STRB_WIDTH-1:0] m_wstrb_q;

  logic aw_hs, w_hs, m_b_hs;

  assign aw_hs  = s_axil_awvalid && s_awready_q;
  assign w_hs   = s_axil_wvalid && s_wready_q;
  assign m_b_hs = m_axil_bvalid && m_bready_q;

  always_comb begin
    state_d     = state_q;
    s_awready_d = 1'b0;
    s_wready_d  = 1'b0;
    aw_cap_d    = aw_cap_q;
    w_cap_d     = w_cap_q;
    m_awvalid_d = m_awvalid_q && !m_axil_awready;
    m_wvalid_d  = m_wvalid_q && !m_axil_wready;
    m_bready_d  = 1'b0;
    s_bvalid_d  = s_bvalid_q && !s_axil_bready;
    s_bresp_d   = s_bresp_q;
    unique case (state_q)
      IDLE: begin
        aw_cap_d = aw_cap_q || aw_hs;
        w_cap_d  = w_cap_q || w_hs;
        if (aw_cap_d && w_cap_d) begin
          m_awvalid_d = 1'b1;
          m_wvalid_d  = 1'b1;
          aw_cap_d    = 1'b0;
          w_cap_d     = 1'b0;
          state_d     = ISSUE;
        end else begin
          s_awready_d = !aw_cap_d && !m_awvalid_q;
          s_wready_d  = !w_cap_d && !m_wvalid_q;
        end
      end
      ISSUE: begin
        if (!m_awvalid_d && !m_wvalid_d) begin
          m_bready_d = !s_bvalid_d;
          state_d    = RESP;
        end
      end
      RESP: begin
        // Hold off the downstream response until the upstream slot is free.
        m_bready_d = !s_bvalid_d;
        if (m_b_hs) begin
          s_bresp_d   = m_axil_bresp;
          s_bvalid_d  = 1'b1;
          m_bready_d  = 1'b0;
          s_awready_d = 1'b1;
          s_wready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_awready_q <= 1'b0;
      s_wready_q  <= 1'b0;
      s_bvalid_q  <= 1'b0;
      s_bresp_q   <= 2'b00;
      m_awvalid_q <= 1'b0;
      m_wvalid_q  <= 1'b0;
      m_bready_q  <= 1'b0;
      aw_cap_q    <= 1'b0;
      w_cap_q     <= 1'b0;
      m_awaddr_q  <= '0;
      m_awprot_q  <= 3'b000;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_awready_q <= s_awready_d;
      s_wready_q  <= s_wready_d;
      s_bvalid_q  <= s_bvalid_d;
      s_bresp_q   <= s_bresp_d;
      m_awvalid_q <= m_awvalid_d;
      m_wvalid_q  <= m_wvalid_d;
      m_bready_q  <= m_bready_d;
      aw_cap_q    <= aw_cap_d;
      w_cap_q     <= w_cap_d;
      // Readies are only high in IDLE, so the downstream registers are idle when written.
      if (aw_hs) begin
        m_awaddr_q <= s_axil_awaddr;
        m_awprot_q <= s_axil_awprot;
      end
      if (w_hs) begin
        m_wdata_q <= s_axil_wdata;
        m_wstrb_q <= s_axil_wstrb;
      end
    end
  end

  assign s_axil_awready = s_awready_q;
  assign s_axil_wready  = s_wready_q;
  assign s_axil_bresp   = s_bresp_q;
  assign s_axil_bvalid  = s_bvalid_q;
  assign m_axil_awaddr  = m_awaddr_q;
  assign m_axil_awprot  = m_awprot_q;
  assign m_axil_awvalid = m_awvalid_q;
  assign m_axil_wdata   = m_wdata_q;
  assign m_axil_wstrb   = m_wstrb_q;
  assign m_axil_wvalid  = m_wvalid_q;
  assign m_axil_bready  = m_bready_q;

endmodule

// File: tb/tb_axil_mitm_wr.sv
// Bench for axil_mitm_wr: directed vector table, hand-written corner sequences and a
// streamed run, with a downstream slave model and an in-order expected queue.
`timescale 1ns/1ps
module tb_axil_mitm_wr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int BUDGET = 300;
  localparam int NR = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s_axil_awaddr;
  logic [2:0]    s_axil_awprot;
  logic          s_axil_awvalid, s_axil_awready;
  logic [DW-1:0] s_axil_wdata;
  logic [SW-1:0] s_axil_wstrb;
  logic          s_axil_wvalid, s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid, s_axil_bready;
  logic [AW-1:0] m_axil_awaddr;
  logic [2:0]    m_axil_awprot;
  logic          m_axil_awvalid, m_axil_awready;
  logic [DW-1:0] m_axil_wdata;
  logic [SW-1:0] m_axil_wstrb;
  logic          m_axil_wvalid, m_axil_wready;
  logic [1:0]    m_axil_bresp;
  logic          m_axil_bvalid, m_axil_bready;

  always #5 clk = ~clk;

  axil_mitm_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [1:0]    resp;
    int            aw_pre, w_pre, m_aw_dly, m_w_dly, m_b_dly, b_dly;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_prot;
    logic [DW-1:0] exp_data;
    logic [SW-1:0] exp_strb;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t tbl[6];
  vec_t rst_vec;

  int n_pass, n_total, cyc;
  logic [AW+2:0]   aw_exp_q[$];
  logic [DW+SW-1:0] w_exp_q[$];
  logic [1:0]      resp_q[$];
  int  m_aw_dly, m_w_dly, m_b_dly;
  bit  rand_mode;
  int  aw_done, w_done, mb_hs_cyc, b_seen_cyc;
  int  bad_bready, bad_order, stall_cnt, awv_cnt, wv_cnt;

  logic [AW-1:0] r_addr[NR];
  logic [2:0]    r_prot[NR];
  logic [DW-1:0] r_data[NR];
  logic [SW-1:0] r_strb[NR];
  logic [1:0]    r_resp[NR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_aw(input logic [AW-1:0] a, input logic [2:0] p, input int pre);
    int n = 0;
    repeat (pre) step();
    s_axil_awaddr  = a;
    s_axil_awprot  = p;
    s_axil_awvalid = 1'b1;
    while (!s_axil_awready && n < BUDGET) begin step(); n++; end
    if (!s_axil_awready) begin
      n_total++;
      $display("FAIL s_aw_timeout: awready 0 after %0d cycles, expected 1", n);
    end else step();
    s_axil_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input int pre);
    int n = 0;
    repeat (pre) step();
    s_axil_wdata  = d;
    s_axil_wstrb  = s;
    s_axil_wvalid = 1'b1;
    while (!s_axil_wready && n < BUDGET) begin step(); n++; end
    if (!s_axil_wready) begin
      n_total++;
      $display("FAIL s_w_timeout: wready 0 after %0d cycles, expected 1", n);
    end else step();
    s_axil_wvalid = 1'b0;
  endtask

  task automatic get_b(input logic [1:0] exp, input int dly);
    int n = 0;
    while (!s_axil_bvalid && n < BUDGET) begin step(); n++; end
    if (!s_axil_bvalid) begin
      n_total++;
      $display("FAIL s_b_timeout: bvalid 0 after %0d cycles, expected 1", n);
      return;
    end
    b_seen_cyc = cyc;
    chk("s_bresp", s_axil_bresp, exp);
    repeat (dly) step();
    s_axil_bready = 1'b1;
    step();
    s_axil_bready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    m_aw_dly = v.m_aw_dly;
    m_w_dly  = v.m_w_dly;
    m_b_dly  = v.m_b_dly;
    aw_exp_q.push_back({v.exp_addr, v.exp_prot});
    w_exp_q.push_back({v.exp_data, v.exp_strb});
    resp_q.push_back(v.resp);
    fork
      send_aw(v.addr, v.prot, v.aw_pre);
      send_w(v.data, v.strb, v.w_pre);
      get_b(v.exp_resp, v.b_dly);
    join
  endtask

  // Downstream slave model: AW channel.
  initial begin : slave_aw
    int d;
    forever begin
      step();
      if (!rst && m_axil_awvalid) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : m_aw_dly;
        for (int k = 0; k < d && !rst; k++) step();
        if (!rst) begin
          m_axil_awready = 1'b1;
          if (aw_exp_q.size() == 0) begin
            n_total++;
            $display("FAIL m_aw_extra: got addr %0h, expected no request", m_axil_awaddr);
          end else chk("m_aw_fields", {m_axil_awaddr, m_axil_awprot}, aw_exp_q.pop_front());
          step();
          m_axil_awready = 1'b0;
          aw_done++;
        end
      end
    end
  end

  initial begin : slave_w
    int d;
    forever begin
      step();
      if (!rst && m_axil_wvalid) begin
        d = rand_mode ? int'($urandom_range(0, 3)) : m_w_dly;
        for (int k = 0; k < d && !rst; k++) step();
        if (!rst) begin
          m_axil_wready = 1'b1;
          if (w_exp_q.size() == 0) begin
            n_total++;
            $display("FAIL m_w_extra: got data %0h, expected no request", m_axil_wdata);
          end else chk("m_w_fields", {m_axil_wdata, m_axil_wstrb}, w_exp_q.pop_front());
          step();
          m_axil_wready = 1'b0;
          w_done++;
        end
      end
    end
  end

  initial begin : slave_b
    int d, n;
    forever begin
      step();
      if (!rst && aw_done > 0 && w_done > 0) begin
        aw_done--;
        w_done--;
        d = rand_mode ? int'($urandom_range(0, 4)) : m_b_dly;
        for (int k = 0; k < d && !rst; k++) step();
        if (!rst) begin
          m_axil_bvalid = 1'b1;
          m_axil_bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          n = 0;
          while (!m_axil_bready && n < BUDGET && !rst) begin step(); n++; end
          if (m_axil_bready) begin
            mb_hs_cyc = cyc;
            step();
          end else if (!rst) begin
            n_total++;
            $display("FAIL m_b_timeout: bready 0 after %0d cycles, expected 1", n);
          end
          m_axil_bvalid = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      step();
      if (m_axil_bready && s_axil_bvalid) bad_bready++;
      if (m_axil_bready && (m_axil_awvalid || m_axil_wvalid)) bad_order++;
      if (s_axil_bvalid && m_axil_bvalid) stall_cnt++;
      if (m_axil_awvalid) awv_cnt++;
      if (m_axil_wvalid) wv_cnt++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    //          addr          prot  data          strb  resp   awp wp mad mwd mbd bd  exp_addr      ep    exp_data      es    er
    tbl[0] = '{32'h0000_1000, 3'd0, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0000_1000, 3'd0, 32'hDEAD_BEEF, 4'hF, 2'b00};
    tbl[1] = '{32'h0000_0040, 3'd2, 32'hA5A5_0001, 4'h3, 2'b00, 3, 0, 0, 0, 0, 0, 32'h0000_0040, 3'd2, 32'hA5A5_0001, 4'h3, 2'b00};
    tbl[2] = '{32'h8000_0004, 3'd1, 32'h0BAD_F00D, 4'hC, 2'b10, 0, 0, 5, 0, 0, 0, 32'h8000_0004, 3'd1, 32'h0BAD_F00D, 4'hC, 2'b10};
    tbl[3] = '{32'hFFFF_FFFC, 3'd7, 32'hFFFF_FFFF, 4'hF, 2'b11, 0, 1, 1, 2, 4, 3, 32'hFFFF_FFFC, 3'd7, 32'hFFFF_FFFF, 4'hF, 2'b11};
    tbl[4] = '{32'h0000_0000, 3'd0, 32'h0000_0000, 4'h0, 2'b01, 0, 4, 0, 3, 0, 0, 32'h0000_0000, 3'd0, 32'h0000_0000, 4'h0, 2'b01};
    tbl[5] = '{32'h1234_5678, 3'd4, 32'h8765_4321, 4'h9, 2'b00, 2, 2, 2, 6, 2, 1, 32'h1234_5678, 3'd4, 32'h8765_4321, 4'h9, 2'b00};
    rst_vec = '{32'h0000_2000, 3'd0, 32'h1234_5678, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0000_2000, 3'd0, 32'h1234_5678, 4'hF, 2'b00};

    rst = 1'b1;
    s_axil_awaddr = '0; s_axil_awprot = 3'd0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;
    m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = 2'b00; m_axil_bvalid = 1'b0;

    // Reset state and first ready after release.
    repeat (2) step();
    chk("reset_outputs", {s_axil_awready, s_axil_wready, s_axil_bvalid,
                          m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 6'b0);
    chk("reset_addr_data", {m_axil_awaddr, m_axil_wdata, s_axil_bresp}, '0);
    @(negedge clk);
    rst = 1'b0;
    chk("ready_low_at_release", {s_axil_awready, s_axil_wready}, 2'b00);
    step();
    chk("ready_after_reset", {s_axil_awready, s_axil_wready}, 2'b11);

    // Same-cycle AW+W with cycle-exact latency on both sides.
    aw_exp_q.push_back({32'h0000_1000, 3'd0});
    w_exp_q.push_back({32'hDEAD_BEEF, 4'hF});
    resp_q.push_back(2'b00);
    s_axil_awaddr = 32'h0000_1000; s_axil_awprot = 3'd0; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'hDEAD_BEEF; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    step();
    chk("same_cycle_m_valids", {m_axil_awvalid, m_axil_wvalid}, 2'b11);
    chk("same_cycle_m_awaddr", m_axil_awaddr, 32'h0000_1000);
    chk("same_cycle_m_wdata", {m_axil_wdata, m_axil_wstrb}, {32'hDEAD_BEEF, 4'hF});
    chk("same_cycle_readies_drop", {s_axil_awready, s_axil_wready}, 2'b00);
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    get_b(2'b00, 0);
    chk("b_latency", b_seen_cyc, mb_hs_cyc + 1);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // W first, AW three cycles later: nothing downstream until the pair is complete.
    aw_exp_q.push_back({32'h0000_0400, 3'd2});
    w_exp_q.push_back({32'h5555_AAAA, 4'h6});
    resp_q.push_back(2'b00);
    m_aw_dly = 0; m_w_dly = 0; m_b_dly = 0;
    fork
      send_w(32'h5555_AAAA, 4'h6, 0);
      send_aw(32'h0000_0400, 3'd2, 3);
      begin
        for (int k = 0; k < 3; k++) begin
          step();
          chk("w_first_wready_low", s_axil_wready, 1'b0);
          chk("w_first_no_m_request", {m_axil_awvalid, m_axil_wvalid}, 2'b00);
        end
      end
      get_b(2'b00, 0);
    join

    // Slow awready, immediate wready.
    awv_cnt = 0;
    wv_cnt  = 0;
    run_vec(tbl[2]);
    chk("slow_awready_awvalid_cycles", awv_cnt, 6);
    chk("slow_awready_wvalid_cycles", wv_cnt, 1);

    // Upstream B stalled while the next write is already downstream.
    stall_cnt = 0;
    m_aw_dly = 0; m_w_dly = 0; m_b_dly = 0;
    aw_exp_q.push_back({32'h0000_0100, 3'd0});
    aw_exp_q.push_back({32'h0000_0104, 3'd5});
    w_exp_q.push_back({32'h1111_1111, 4'hF});
    w_exp_q.push_back({32'h2222_2222, 4'h5});
    resp_q.push_back(2'b00);
    resp_q.push_back(2'b10);
    fork
      begin send_aw(32'h0000_0100, 3'd0, 0); send_aw(32'h0000_0104, 3'd5, 0); end
      begin send_w(32'h1111_1111, 4'hF, 0); send_w(32'h2222_2222, 4'h5, 0); end
      begin get_b(2'b00, 10); get_b(2'b10, 0); end
    join
    chk("b_stall_second_resp_waited", stall_cnt > 0, 1'b1);

    // Reset while a downstream AW is pending.
    m_aw_dly = 8; m_w_dly = 0; m_b_dly = 0;
    aw_exp_q.push_back({32'h0000_3000, 3'd0});
    w_exp_q.push_back({32'hCAFE_F00D, 4'hF});
    fork
      send_aw(32'h0000_3000, 3'd0, 0);
      send_w(32'hCAFE_F00D, 4'hF, 0);
    join
    chk("issue_awvalid_before_reset", m_axil_awvalid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("reset_mid_issue", {s_axil_awready, s_axil_wready, s_axil_bvalid,
                            m_axil_awvalid, m_axil_wvalid, m_axil_bready}, 6'b0);
    step();
    aw_exp_q.delete();
    w_exp_q.delete();
    resp_q.delete();
    aw_done = 0;
    w_done  = 0;
    @(negedge clk);
    rst = 1'b0;
    step();
    run_vec(rst_vec);

    // Streamed writes with random stalls on both sides.
    for (int i = 0; i < NR; i++) begin
      r_addr[i] = $urandom;
      r_prot[i] = 3'($urandom_range(0, 7));
      r_data[i] = $urandom;
      r_strb[i] = 4'($urandom_range(0, 15));
      r_resp[i] = 2'($urandom_range(0, 3));
      aw_exp_q.push_back({r_addr[i], r_prot[i]});
      w_exp_q.push_back({r_data[i], r_strb[i]});
      resp_q.push_back(r_resp[i]);
    end
    rand_mode = 1'b1;
    fork
      for (int i = 0; i < NR; i++) send_aw(r_addr[i], r_prot[i], int'($urandom_range(0, 2)));
      for (int j = 0; j < NR; j++) send_w(r_data[j], r_strb[j], int'($urandom_range(0, 2)));
      for (int k = 0; k < NR; k++) get_b(r_resp[k], int'($urandom_range(0, 3)));
    join
    rand_mode = 1'b0;

    repeat (5) step();
    chk("aw_queue_drained", aw_exp_q.size(), 0);
    chk("w_queue_drained", w_exp_q.size(), 0);
    chk("resp_queue_drained", resp_q.size(), 0);
    chk("bready_while_bvalid", bad_bready, 0);
    chk("bready_before_issue_done", bad_order, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
